control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Multi-cycle instruction sequencer for the tiny16 CPU; sits directly upstream of the register file.
//  Fetches each instruction through the shared memory port using r0 as PC, then decodes it.
//  Drives register-file selects/enables, ALU op, write-back mux select and memory handshake.
//  ISA: IR[15:12] opcode, IR[11:9] rd, IR[8:6] rs, IR[8:0] imm9 (LDI only).
// PARAMETERS
//  WIDTH      16   datapath / instruction width
//  REG_SEL_W  3    register select width (8 GPRs, r0 = PC)
// PORTS
//  clk        in   1   system clock; all state on posedge
//  rst        in   1   reset, asynchronous, active-low
//  mem_data   in   16  read data from memory (instruction or load data)
//  mem_ready  in   1   memory access complete; sampled only while mem_rd/mem_wr high
//  alu_zero   in   1   ALU zero result flag
//  mem_rd     out  1   memory read request, held until mem_ready
//  mem_wr     out  1   memory write request, held until mem_ready
//  mar_ld     out  1   load memory address register from register-file out bus
//  src_sel    out  3   register-file source select
//  dst_sel    out  3   register-file destination select
//  reg_in_en  out  1   register-file write enable (file writes on negedge)
//  reg_out_en out  1   register-file out-bus enable
//  pc_inc     out  1   increment r0
//  alu_op     out  4   ALU operation (= opcode for 0x5-0xB)
//  alu_en     out  1   ALU result valid / flag update
//  wb_sel     out  2   write-back mux: 0 SRC port, 1 ALU, 2 MEM, 3 IMM
//  imm        out  16  sign-extended imm9
//  halted     out  1   core halted
//  fault      out  1   illegal opcode trap (macro only; else tied 0)
// BEHAVIOUR
//  Reset (rst=0, any state incl. mid-wait): state=ADDR; IR=0; zflag=0; all outputs 0; pending access dropped.
//  Opcodes: 0 NOP, 1 MOV, 2 LDI, 3 LD rd,[rs], 4 ST [rs],rd, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR,
//   A SHL, B SHR, C JMP rs, D JZ rs, E illegal, F HLT.
//  ADDR:   reg_out_en=1, src_sel=0 -> MAR (1 cycle).
//  MAR:    mar_ld=1 -> FETCH (1 cycle).
//  FETCH:  mem_rd=1 until mem_ready; that cycle: IR<=mem_data, pc_inc=1 -> DECODE.
//  DECODE: src_sel=rs, dst_sel=rd, reg_out_en=1 for LD/ST -> EXEC (1 cycle).
//  EXEC:   src_sel/dst_sel held; one cycle; per opcode:
//   NOP -> ADDR. MOV: wb_sel=0, reg_in_en. LDI: wb_sel=3, reg_in_en.
//   ALU (5-B): alu_en, alu_op, wb_sel=1, reg_in_en; zflag<=alu_zero.
//   JMP: dst_sel=0, wb_sel=0, reg_in_en. JZ: same only if zflag=1, else no write.
//   LD/ST: mar_ld=1 -> MEM. HLT -> HALT. All others -> ADDR.
//  MEM: LD: mem_rd until mem_ready; that cycle wb_sel=2, reg_in_en, dst_sel=rd -> ADDR.
//   ST: mem_wr until mem_ready (data from register-file dst port) -> ADDR.
//  HALT: halted=1, all enables 0; exits only by reset.
//  Latency with zero-wait memory: 5 cycles/instr, LD/ST 6; each wait state adds 1.
//  mem_rd and mem_wr never asserted together; mem_ready while idle ignored.
//  pc_inc only in FETCH; writes to r0 (MOV/LDI/ALU/LD rd=0) act as jumps, never collide with pc_inc.
//  imm = {{7{IR[8]}},IR[8:0]}; ALU carry/overflow not tracked here.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined: opcode E in EXEC -> HALT with fault=1 and halted=1 until reset.
//  Undefined: opcode E executes as NOP; fault tied 0.
// STRUCTURE
//  tiny16_pkg: opcode localparams/enum, state enum, wb_sel encodings, WIDTH.
//  Sub-module instr_decode (combinational): IR -> rd, rs, imm, is_alu/is_mem/is_jump/illegal.
// TESTING
//  Reset low mid-FETCH with mem_rd=1 -> next cycle mem_rd=0, state ADDR, all outputs 0.
//  LDI r2,-3 (0x25FD), zero-wait -> cycle 5: dst_sel=2, wb_sel=3, imm=0xFFFD, reg_in_en=1.
//  SUB r3,r3 with alu_zero=1, then JZ r4 -> JZ EXEC: dst_sel=0, wb_sel=0, reg_in_en=1; alu_zero=0 -> no write.
//  LD r1,[r5], mem_ready delayed 3 cycles in MEM -> mem_rd high 4 cycles, single reg_in_en with wb_sel=2.
//  HLT (0xF000) -> halted=1 after EXEC, no mem_rd/pc_inc for 20 further cycles.
//  Opcode 0xE000: with CTRL_ILLEGAL_TRAP_EN -> fault=1, halted=1; without -> next fetch at PC+1.

Source files
------------

// File: rtl/tiny16_pkg.sv
// Shared types and constants for the tiny16 control unit: ISA opcodes,
// sequencer states and write-back mux encodings.
package tiny16_pkg;

  localparam int WIDTH     = 16;
  localparam int REG_SEL_W = 3;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_MOV = 4'h1,
    OP_LDI = 4'h2,
    OP_LD  = 4'h3,
    OP_ST  = 4'h4,
    OP_ADD = 4'h5,
    OP_SUB = 4'h6,
    OP_AND = 4'h7,
    OP_OR  = 4'h8,
    OP_XOR = 4'h9,
    OP_SHL = 4'hA,
    OP_SHR = 4'hB,
    OP_JMP = 4'hC,
    OP_JZ  = 4'hD,
    OP_ILL = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_ADDR   = 3'd0,
    S_MAR    = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] WB_SRC = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

endpackage

// File: rtl/control_unit_if.sv
// Memory port of the tiny16 control unit (instruction fetch and LD/ST data).
// Handshake: mem_rd/mem_wr is held high until the cycle mem_ready is seen high,
// which completes the access; mem_ready outside a request carries no meaning.
interface control_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] mem_data;
  logic             mem_ready;
  logic             mem_rd;
  logic             mem_wr;
  logic             mar_ld;

  modport master (input mem_data, mem_ready, output mem_rd, mem_wr, mar_ld);
  modport slave  (output mem_data, mem_ready, input mem_rd, mem_wr, mar_ld);
endinterface

// File: rtl/control_unit_instr_decode.sv
// Combinational field extraction and opcode classification for the tiny16 IR.
module instr_decode
  import tiny16_pkg::*;
#(
  parameter int WIDTH = tiny16_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] ir,
  output opcode_t          opcode,
  output logic [2:0]       rd,
  output logic [2:0]       rs,
  output logic [WIDTH-1:0] imm,
  output logic             is_alu,
  output logic             is_mem,
  output logic             is_jump,
  output logic             illegal
);

  assign opcode  = opcode_t'(ir[15:12]);
  assign rd      = ir[11:9];
  assign rs      = ir[8:6];
  assign imm     = {{(WIDTH-9){ir[8]}}, ir[8:0]};
  assign is_alu  = (ir[15:12] >= 4'h5) && (ir[15:12] <= 4'hB);
  assign is_mem  = (opcode == OP_LD) || (opcode == OP_ST);
  assign is_jump = (opcode == OP_JMP) || (opcode == OP_JZ);
  assign illegal = (opcode == OP_ILL);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the tiny16 CPU.
// Define CTRL_ILLEGAL_TRAP_EN to trap opcode 0xE into HALT with fault raised.
module control_unit
  import tiny16_pkg::*;
#(
  parameter int WIDTH     = tiny16_pkg::WIDTH,
  parameter int REG_SEL_W = tiny16_pkg::REG_SEL_W
) (
  input  logic                 clk,
  input  logic                 rst,
  control_unit_if.master       mem,
  input  logic                 alu_zero,
  output logic [REG_SEL_W-1:0] src_sel,
  output logic [REG_SEL_W-1:0] dst_sel,
  output logic                 reg_in_en,
  output logic                 reg_out_en,
  output logic                 pc_inc,
  output logic [3:0]           alu_op,
  output logic                 alu_en,
  output logic [1:0]           wb_sel,
  output logic [WIDTH-1:0]     imm,
  output logic                 halted,
  output logic                 fault,
  output state_t               dbg_state
);

  state_t           state, next_state;
  logic [WIDTH-1:0] ir;
  logic             zflag;
  logic             ir_ld, z_ld;

  opcode_t    opcode;
  logic [2:0] rd, rs;
  logic       is_alu, is_mem, is_jump, illegal;

  instr_decode #(.WIDTH(WIDTH)) u_decode (
    .ir      (ir),
    .opcode  (opcode),
    .rd      (rd),
    .rs      (rs),
    .imm     (imm),
    .is_alu  (is_alu),
    .is_mem  (is_mem),
    .is_jump (is_jump),
    .illegal (illegal)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic fault_q, fault_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          fault_q <= 1'b0;
    else if (fault_set) fault_q <= 1'b1;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_ADDR;
      ir    <= '0;
      zflag <= 1'b0;
    end else begin
      state <= next_state;
      if (ir_ld) ir    <= mem.mem_data;
      if (z_ld)  zflag <= alu_zero;
    end
  end

  assign dbg_state = state;

  // Outputs are forced low while reset is held so ADDR's bus enable stays quiet.
  always_comb begin
    next_state     = state;
    ir_ld          = 1'b0;
    z_ld           = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    fault_set      = 1'b0;
`endif
    mem.mem_rd     = 1'b0;
    mem.mem_wr     = 1'b0;
    mem.mar_ld     = 1'b0;
    src_sel        = '0;
    dst_sel        = '0;
    reg_in_en      = 1'b0;
    reg_out_en     = 1'b0;
    pc_inc         = 1'b0;
    alu_op         = '0;
    alu_en         = 1'b0;
    wb_sel         = WB_SRC;
    halted         = 1'b0;
    if (rst) begin
      case (state)
        S_ADDR: begin
          reg_out_en = 1'b1;
          next_state = S_MAR;
        end
        S_MAR: begin
          mem.mar_ld = 1'b1;
          next_state = S_FETCH;
        end
        S_FETCH: begin
          mem.mem_rd = 1'b1;
          if (mem.mem_ready) begin
            ir_ld      = 1'b1;
            pc_inc     = 1'b1;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          src_sel    = rs;
          dst_sel    = rd;
          reg_out_en = is_mem;
          next_state = S_EXEC;
        end
        S_EXEC: begin
          src_sel    = rs;
          dst_sel    = rd;
          next_state = S_ADDR;
          if (is_alu) begin
            alu_en    = 1'b1;
            alu_op    = opcode;
            wb_sel    = WB_ALU;
            reg_in_en = 1'b1;
            z_ld      = 1'b1;
          end else if (is_mem) begin
            reg_out_en = 1'b1;
            mem.mar_ld = 1'b1;
            next_state = S_MEM;
          end else if (is_jump) begin
            // Jumps are a plain copy of rs into r0; JZ only when the last ALU result was zero.
            dst_sel   = '0;
            wb_sel    = WB_SRC;
            reg_in_en = (opcode == OP_JMP) || zflag;
          end else if (opcode == OP_MOV) begin
            wb_sel    = WB_SRC;
            reg_in_en = 1'b1;
          end else if (opcode == OP_LDI) begin
            wb_sel    = WB_IMM;
            reg_in_en = 1'b1;
          end else if (opcode == OP_HLT) begin
            next_state = S_HALT;
          end else if (illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            fault_set  = 1'b1;
            next_state = S_HALT;
`else
            next_state = S_ADDR;
`endif
          end
        end
        S_MEM: begin
          src_sel = rs;
          dst_sel = rd;
          if (opcode == OP_LD) begin
            mem.mem_rd = 1'b1;
            if (mem.mem_ready) begin
              wb_sel     = WB_MEM;
              reg_in_en  = 1'b1;
              next_state = S_ADDR;
            end
          end else begin
            mem.mem_wr = 1'b1;
            if (mem.mem_ready) next_state = S_ADDR;
          end
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: next_state = S_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit: a memory responder feeds a
// program, a reference model predicts write-backs and per-instruction latency.
module tb_control_unit;
  import tiny16_pkg::*;

  localparam int EW = 29;  // {dst3, wb2, alu_en1, alu_op4, src3, imm16}

  typedef struct {
    logic [15:0] instr;
    int          fw;
    int          dw;
    logic        az;
  } prog_t;

  logic        clk, rst, alu_zero;
  logic [2:0]  src_sel, dst_sel;
  logic        reg_in_en, reg_out_en, pc_inc, alu_en, halted, fault;
  logic [3:0]  alu_op;
  logic [1:0]  wb_sel;
  logic [15:0] imm;
  state_t      dbg_state;

  control_unit_if #(.WIDTH(16)) mif ();

  control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (mif.master),
    .alu_zero   (alu_zero),
    .src_sel    (src_sel),
    .dst_sel    (dst_sel),
    .reg_in_en  (reg_in_en),
    .reg_out_en (reg_out_en),
    .pc_inc     (pc_inc),
    .alu_op     (alu_op),
    .alu_en     (alu_en),
    .wb_sel     (wb_sel),
    .imm        (imm),
    .halted     (halted),
    .fault      (fault),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int             n_checks = 0;
  int             n_fail   = 0;
  logic [EW-1:0]  exp_q[$];
  int             lat_q[$];
  prog_t          prog_q[$];
  prog_t          cur;
  logic           exp_fault;
  logic           mdl_z;
  logic           have_prev;
  logic           prev_mem;
  int             prev_dw;
  logic           chk_first;
  int             cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=event required=no-event (t=%0t)", name, $time);
  endtask

  task automatic add(input logic [15:0] instr, input int fw, input int dw, input logic az);
    prog_t e;
    e.instr = instr; e.fw = fw; e.dw = dw; e.az = az;
    prog_q.push_back(e);
  endtask

  function automatic logic [EW-1:0] mk(input int dst, input int wb, input int aen,
                                        input int aop, input int src, input int immv);
    logic [2:0]  d = dst[2:0];
    logic [1:0]  w = wb[1:0];
    logic        a = aen[0];
    logic [3:0]  o = aop[3:0];
    logic [2:0]  s = src[2:0];
    logic [15:0] i = immv[15:0];
    return {d, w, a, o, s, i};
  endfunction

  // Reference model: what one fetched instruction must cause, from the ISA rules.
  task automatic model(input prog_t e);
    int op, rd, rs, immv;
    op   = int'(e.instr[15:12]);
    rd   = int'(e.instr[11:9]);
    rs   = int'(e.instr[8:6]);
    immv = int'(e.instr[8:0]);
    if (immv >= 256) immv = immv - 512;
    if (have_prev) lat_q.push_back(5 + e.fw + (prev_mem ? 1 + prev_dw : 0));
    have_prev = 1'b1;
    prev_mem  = (op == 3) || (op == 4);
    prev_dw   = e.dw;
    if (op == 1)                      exp_q.push_back(mk(rd, 0, 0, 0, rs, 0));
    else if (op == 2)                 exp_q.push_back(mk(rd, 3, 0, 0, 0, immv));
    else if (op == 3)                 exp_q.push_back(mk(rd, 2, 0, 0, 0, 0));
    else if (op >= 5 && op <= 11) begin
      exp_q.push_back(mk(rd, 1, 1, op, 0, 0));
      mdl_z = e.az;
    end
    else if (op == 12 || (op == 13 && mdl_z)) exp_q.push_back(mk(0, 0, 0, 0, rs, 0));
`ifdef CTRL_ILLEGAL_TRAP_EN
    else if (op == 14)                exp_fault = 1'b1;
`endif
  endtask

  // ---------------- memory responder (driver) ----------------
  initial begin : memory
    logic busy, is_data, data_next;
    int   cnt;
    busy = 1'b0; is_data = 1'b0; data_next = 1'b0; cnt = 0;
    mif.mem_ready = 1'b0;
    mif.mem_data  = '0;
    alu_zero      = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        busy = 1'b0; data_next = 1'b0;
        mif.mem_ready = 1'b0; mif.mem_data = '0; alu_zero = 1'b0;
        mdl_z = 1'b0; have_prev = 1'b0; exp_fault = 1'b0;
      end else if (mif.mem_rd || mif.mem_wr) begin
        if (!busy) begin
          busy = 1'b1;
          if (data_next) begin
            is_data = 1'b1;
            cnt     = cur.dw;
            check("mem_direction", {mif.mem_rd, mif.mem_wr},
                  (cur.instr[15:12] == 4'h3) ? 2'b10 : 2'b01);
            mif.mem_data = 16'($urandom);
          end else begin
            is_data = 1'b0;
            if (prog_q.size() == 0) begin
              fail_now("fetch_underflow");
              cur.instr = 16'hF000; cur.fw = 0; cur.dw = 0; cur.az = 1'b0;
            end else begin
              cur = prog_q.pop_front();
            end
            cnt          = cur.fw;
            mif.mem_data = cur.instr;
          end
        end
        if (cnt == 0) begin
          mif.mem_ready = 1'b1;
          busy          = 1'b0;
          if (is_data) begin
            data_next = 1'b0;
            if (mif.mem_wr) check("st_data_reg", dst_sel, cur.instr[11:9]);
          end else begin
            alu_zero  = cur.az;
            model(cur);
            data_next = (cur.instr[15:12] == 4'h3) || (cur.instr[15:12] == 4'h4);
          end
        end else begin
          mif.mem_ready = 1'b0;
          cnt--;
        end
      end else begin
        mif.mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [EW-1:0] e;
    logic          have_last;
    int            last_cyc;
    have_last = 1'b0; last_cyc = 0; cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cyc = 0; have_last = 1'b0;
      end else begin
        cyc++;
        if (mif.mem_rd || mif.mem_wr) check("rd_wr_exclusive", mif.mem_rd & mif.mem_wr, 1'b0);
        if (reg_in_en) begin
          if (chk_first) begin
            check("first_write_cycle", cyc, 5);
            chk_first = 1'b0;
          end
          if (exp_q.size() == 0) fail_now("unexpected_write");
          else begin
            e = exp_q.pop_front();
            check("wb_dst", dst_sel, e[28:26]);
            check("wb_sel", wb_sel, e[25:24]);
            check("wb_alu_en", alu_en, e[23]);
            if (e[25:24] == WB_ALU) check("wb_alu_op", alu_op, e[22:19]);
            if (e[25:24] == WB_SRC) check("wb_src", src_sel, e[18:16]);
            if (e[25:24] == WB_IMM) check("wb_imm", imm, e[15:0]);
          end
        end
        if (pc_inc) begin
          if (have_last) begin
            if (lat_q.size() == 0) fail_now("unexpected_fetch");
            else check("instr_latency", cyc - last_cyc, lat_q.pop_front());
          end
          have_last = 1'b1;
          last_cyc  = cyc;
        end
      end
    end
  end

  // ---------------- sequences ----------------
  task automatic enter_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    prog_q.delete(); exp_q.delete(); lat_q.delete();
  endtask

  task automatic leave_reset();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic wait_halt_and_check(input int quiet);
    int i;
    for (i = 0; i < 4000 && !halted; i++) @(negedge clk);
    if (!halted) begin
      fail_now("halt_timeout");
    end else begin
      check("halt_state", dbg_state, S_HALT);
      check("halt_fault", fault, exp_fault);
      for (int k = 0; k < quiet; k++) begin
        @(negedge clk);
        check("halt_quiet", {mif.mem_rd, mif.mem_wr, pc_inc, reg_in_en, alu_en}, 5'b0);
        check("halt_held", halted, 1'b1);
      end
    end
    check("exp_q_drained", exp_q.size(), 0);
    check("lat_q_drained", lat_q.size(), 0);
  endtask

  initial begin : main
    int i;
    logic [3:0]  op;
    logic [11:0] fld;
    rst = 1'b0;
    chk_first = 1'b0;
    repeat (3) @(posedge clk);

    // Reset dropped in the middle of a stalled fetch.
    add(16'h0000, 8, 0, 1'b0);
    leave_reset();
    for (i = 0; i < 20 && !mif.mem_rd; i++) @(negedge clk);
    check("fetch_started", mif.mem_rd, 1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_rd", mif.mem_rd, 1'b0);
    check("rst_state", dbg_state, S_ADDR);
    check("rst_outputs", {mif.mem_wr, mif.mar_ld, src_sel, dst_sel, reg_in_en, reg_out_en,
                          pc_inc, alu_op, alu_en, wb_sel, imm, halted, fault}, 64'd0);
    enter_reset();

    // Directed opening followed by random instructions.
    add(16'h25FD, 0, 0, 1'b0);  // LDI r2,-3
    add(16'h66C0, 1, 0, 1'b1);  // SUB r3,r3 -> zero
    add(16'hD100, 0, 0, 1'b0);  // JZ r4 taken
    add(16'h66C0, 0, 0, 1'b0);  // SUB r3,r3 -> non-zero
    add(16'hD100, 2, 0, 1'b1);  // JZ r4 not taken
    add(16'h3340, 0, 3, 1'b0);  // LD r1,[r5] with 3 wait states
    add(16'h4340, 1, 1, 1'b0);  // ST [r5],r1
    add(16'h1040, 0, 0, 1'b0);  // MOV r0,r1
    for (int n = 0; n < 50; n++) begin
      op  = 4'($urandom_range(0, 13));
      fld = 12'($urandom);
      add({op, fld}, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    add(16'hF000, 0, 0, 1'b0);
    chk_first = 1'b1;
    leave_reset();
    wait_halt_and_check(20);

    // Opcode 0xE: trapped or executed as NOP depending on build.
    enter_reset();
    add(16'hE000, 0, 0, 1'b0);
    add(16'h0000, 1, 0, 1'b0);
    add(16'hF000, 0, 0, 1'b0);
    leave_reset();
    wait_halt_and_check(5);
`ifndef CTRL_ILLEGAL_TRAP_EN
    check("illegal_runs_on", prog_q.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
